// File: rtl/mpsoc_sysid_pkg.sv
// Register map, CTRL bit layout and CONFIG word layout shared by the
// MPSoC system-ID / housekeeping slave and its uptime counter.
package mpsoc_sysid_pkg;

  // Word offsets inside the low page (address < ADDR_SCRATCH_BASE).
  typedef enum logic [2:0] {
    ADDR_SYSID     = 3'd0,
    ADDR_TIMESTAMP = 3'd1,
    ADDR_CONFIG    = 3'd2,
    ADDR_CTRL      = 3'd3,
    ADDR_UPTIME_LO = 3'd4,
    ADDR_UPTIME_HI = 3'd5,
    ADDR_SEM       = 3'd6,
    ADDR_RESERVED  = 3'd7
  } reg_off_e;

  localparam int ADDR_SCRATCH_BASE = 8;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_CLR_BIT  = 1;
  localparam int CTRL_WRAP_BIT = 2;

  localparam logic [7:0] VERSION_DEFAULT = 8'h02;

  typedef struct packed {
    logic [7:0] version;
    logic [7:0] num_scratch;
    logic [7:0] reserved;
    logic [7:0] num_cores;
  } config_t;

  function automatic logic [31:0] pack_config(input logic [7:0] version,
                                              input int         num_scratch,
                                              input int         num_cores);
    config_t cfg;
    cfg.version     = version;
    cfg.num_scratch = 8'(num_scratch);
    cfg.reserved    = 8'h00;
    cfg.num_cores   = 8'(num_cores);
    return cfg;
  endfunction

endpackage

// File: rtl/mpsoc_uptime_ctr.sv
// Free-running 64-bit uptime counter with synchronous clear, wrap pulse and
// a high-word shadow captured when the low word is read.
module mpsoc_uptime_ctr (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        en,
  input  logic        clr,
  input  logic        snap,
  output logic [31:0] count_lo,
  output logic [31:0] hi_shadow,
  output logic        wrap_pulse
);

  logic [63:0] count_q;
  logic [31:0] hi_shadow_q;

  // Clear takes priority, so a clear on the terminal count never reports a wrap.
  assign wrap_pulse = en && !clr && (count_q == '1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of block ordering.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + 64'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hi_shadow_q <= '0;
    end else if (snap) begin
      hi_shadow_q <= count_q[63:32];
    end
  end

  assign count_lo  = count_q[31:0];
  assign hi_shadow = hi_shadow_q;

endmodule

// File: rtl/mpsoc_sysid_ctrl.sv
// System-ID and housekeeping Avalon-MM slave: ID words, uptime counter with
// atomic snapshot, boot semaphore and scratch registers; 1-cycle read latency.
module mpsoc_sysid_ctrl
  import mpsoc_sysid_pkg::*;
#(
  parameter logic [31:0] SYS_ID      = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP   = 32'h0000_0000,
  parameter int          NUM_CORES   = 4,
  parameter int          NUM_SCRATCH = 4,
  parameter int          ADDR_W      = 4,
  parameter logic [7:0]  VERSION     = VERSION_DEFAULT
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata
);

  localparam logic [31:0] CONFIG_WORD = pack_config(VERSION, NUM_SCRATCH, NUM_CORES);

  logic              low_page;
  logic [2:0]        low_off;
  logic [ADDR_W-1:0] scratch_off;
  logic              scratch_hit;
  logic              wr_en;
  logic              ctrl_wr;
  logic              clr;
  logic              snap;
  logic              sem_rd;
  logic              sem_wr;

  logic              en_q;
  logic              wrap_q;
  logic              lock_q;
  logic [31:0]       scratch_q [NUM_SCRATCH];

  logic [31:0]       count_lo;
  logic [31:0]       hi_shadow;
  logic              wrap_pulse;
  logic [31:0]       ctrl_word;
  logic [31:0]       rd_mux;

  assign low_page    = (address[ADDR_W-1:3] == '0);
  assign low_off     = address[2:0];
  assign scratch_off = address - ADDR_W'(ADDR_SCRATCH_BASE);
  assign scratch_hit = !low_page && (32'(scratch_off) < $unsigned(NUM_SCRATCH));

  // A read and write in the same cycle is illegal on the fabric; the read wins.
  assign wr_en   = write && !read;
  assign ctrl_wr = wr_en && low_page && (low_off == ADDR_CTRL);
  assign clr     = ctrl_wr && writedata[CTRL_CLR_BIT];
  assign snap    = read && low_page && (low_off == ADDR_UPTIME_LO);
  assign sem_rd  = read && low_page && (low_off == ADDR_SEM);
  assign sem_wr  = wr_en && low_page && (low_off == ADDR_SEM);

  mpsoc_uptime_ctr u_uptime (
    .clock      (clock),
    .reset_n    (reset_n),
    .en         (en_q),
    .clr        (clr),
    .snap       (snap),
    .count_lo   (count_lo),
    .hi_shadow  (hi_shadow),
    .wrap_pulse (wrap_pulse)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      en_q   <= 1'b1;
      wrap_q <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        en_q <= writedata[CTRL_EN_BIT];
      end
      // A wrap on the same edge as a write-1-to-clear keeps WRAP set.
      wrap_q <= wrap_pulse || (wrap_q && !(ctrl_wr && writedata[CTRL_WRAP_BIT]));
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lock_q <= 1'b0;
    end else if (sem_rd) begin
      lock_q <= 1'b1;
    end else if (sem_wr) begin
      lock_q <= 1'b0;
    end
  end

  // NOTE: the scratch bank is software-visible state with a defined reset
  // value, so it is built from resettable flops rather than a RAM macro.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        scratch_q[i] <= '0;
      end
    end else if (wr_en && scratch_hit) begin
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        if (scratch_off == ADDR_W'(i)) begin
          scratch_q[i] <= writedata;
        end
      end
    end
  end

  always_comb begin
    ctrl_word                = '0;
    ctrl_word[CTRL_EN_BIT]   = en_q;
    ctrl_word[CTRL_WRAP_BIT] = wrap_q;
  end

  always_comb begin
    // NOTE: default first so every path assigns rd_mux and no latch is inferred.
    rd_mux = '0;
    if (low_page) begin
      case (reg_off_e'(low_off))
        ADDR_SYSID:     rd_mux = SYS_ID;
        ADDR_TIMESTAMP: rd_mux = TIMESTAMP;
        ADDR_CONFIG:    rd_mux = CONFIG_WORD;
        ADDR_CTRL:      rd_mux = ctrl_word;
        ADDR_UPTIME_LO: rd_mux = count_lo;
        ADDR_UPTIME_HI: rd_mux = hi_shadow;
        ADDR_SEM:       rd_mux = {31'b0, lock_q};
        default:        rd_mux = '0;
      endcase
    end else if (scratch_hit) begin
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        if (scratch_off == ADDR_W'(i)) begin
          rd_mux = scratch_q[i];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else if (read) begin
      readdata <= rd_mux;
    end
  end

endmodule
